// File: rtl/pid_ctrl_gen2_if.sv
// Heading-error / wheel-speed bundle between the error source, the PID core and the motor drive.
// master drives error, gains and forward speed; slave returns the speed pair.
interface pid_ctrl_gen2_if #(
  parameter int ERR_W   = 12,
  parameter int FRWRD_W = 10,
  parameter int SPD_W   = 11,
  parameter int PC_W    = 6,
  parameter int DC_W    = 5
);
  logic                    err_vld;
  logic signed [ERR_W-1:0] error;
  logic                    moving;
  logic [FRWRD_W-1:0]      frwrd;
  logic [PC_W-1:0]         p_coeff;
  logic [DC_W-1:0]         d_coeff;
  logic                    spd_vld;
  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;

  modport master (
    output err_vld, error, moving, frwrd, p_coeff, d_coeff,
    input  spd_vld, lft_spd, rght_spd
  );

  modport slave (
    input  err_vld, error, moving, frwrd, p_coeff, d_coeff,
    output spd_vld, lft_spd, rght_spd
  );
endinterface

// File: rtl/pid_ctrl_gen2.sv
// Three-stage PID heading controller: saturate error, form P/I/D with a clamping integrator,
// then mix the scaled PID sum with forward speed into saturated left/right wheel speeds.
module pid_ctrl_gen2 #(
  parameter int ERR_W     = 12,
  parameter int SAT_W     = 10,
  parameter int DSAT_W    = 8,
  parameter int FRWRD_W   = 10,
  parameter int SPD_W     = 11,
  parameter int INT_W     = 15,
  parameter int I_SHIFT   = 6,
  parameter int D_DEPTH   = 3,
  parameter int PC_W      = 6,
  parameter int DC_W      = 5,
  parameter int OUT_SHIFT = 3
) (
  input logic           clk,
  input logic           rst_n,
  pid_ctrl_gen2_if.slave bus
);

  localparam int PW = SAT_W + PC_W + 1;
  localparam int DW = DSAT_W + DC_W + 1;
  localparam int IW = INT_W - I_SHIFT;
  localparam int SW = PW + 2;
  localparam int MW = ((SW > FRWRD_W + 1) ? SW : FRWRD_W + 1) + 1;

  localparam logic signed [ERR_W-1:0] E_MAX  = ERR_W'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [ERR_W-1:0] E_MIN  = ~E_MAX;
  localparam logic signed [SAT_W:0]   DD_MAX = (SAT_W + 1)'((1 << (DSAT_W - 1)) - 1);
  localparam logic signed [SAT_W:0]   DD_MIN = ~DD_MAX;
  localparam logic signed [INT_W:0]   IS_MAX = (INT_W + 1)'((1 << (INT_W - 1)) - 1);
  localparam logic signed [INT_W:0]   IS_MIN = ~IS_MAX;
  localparam logic signed [MW-1:0]    S_MAX  = MW'((1 << (SPD_W - 1)) - 1);
  localparam logic signed [MW-1:0]    S_MIN  = ~S_MAX;

  logic [2:0]              vld_q;
  logic signed [SAT_W-1:0] es_q, es_d;
  logic signed [SAT_W-1:0] hist_q [D_DEPTH];
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic signed [DW-1:0]    d_q, d_d;
  logic signed [IW-1:0]    i_q, i_d;
  logic signed [SPD_W-1:0] lft_q, lft_d, rght_q, rght_d;
  logic signed [SAT_W:0]   dd_full;
  logic signed [DSAT_W-1:0] dd_sat;
  logic signed [INT_W:0]   isum;
  logic signed [SW-1:0]    pid, t;
  logic signed [MW-1:0]    lsum, rsum;

  function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [MW-1:0] x);
    if (x > S_MAX)      return S_MAX[SPD_W-1:0];
    else if (x < S_MIN) return S_MIN[SPD_W-1:0];
    else                return x[SPD_W-1:0];
  endfunction

  // S1: error saturation
  always_comb begin
    if (bus.error > E_MAX)      es_d = E_MAX[SAT_W-1:0];
    else if (bus.error < E_MIN) es_d = E_MIN[SAT_W-1:0];
    else                        es_d = bus.error[SAT_W-1:0];
  end

  // S2: overflow is judged on the one-bit-wider sum so the integrator clamps instead of wrapping
  always_comb begin
    p_d     = PW'(es_q) * PW'($signed({1'b0, bus.p_coeff}));
    dd_full = (SAT_W + 1)'(es_q) - (SAT_W + 1)'(hist_q[D_DEPTH-1]);
    if (dd_full > DD_MAX)      dd_sat = DD_MAX[DSAT_W-1:0];
    else if (dd_full < DD_MIN) dd_sat = DD_MIN[DSAT_W-1:0];
    else                       dd_sat = dd_full[DSAT_W-1:0];
    d_d     = DW'(dd_sat) * DW'($signed({1'b0, bus.d_coeff}));
    isum    = (INT_W + 1)'(integ_q) + (INT_W + 1)'(es_q);
    if (isum > IS_MAX)      integ_d = IS_MAX[INT_W-1:0];
    else if (isum < IS_MIN) integ_d = IS_MIN[INT_W-1:0];
    else                    integ_d = isum[INT_W-1:0];
    i_d     = IW'(integ_d >>> I_SHIFT);
  end

  // S3: speed mix
  always_comb begin
    pid    = SW'(p_q >>> 1) + SW'(i_q) + SW'(d_q);
    t      = pid >>> OUT_SHIFT;
    lsum   = MW'($signed({1'b0, bus.frwrd})) + MW'(t);
    rsum   = MW'($signed({1'b0, bus.frwrd})) - MW'(t);
    lft_d  = bus.moving ? sat_spd(lsum) : '0;
    rght_d = bus.moving ? sat_spd(rsum) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      es_q    <= '0;
      integ_q <= '0;
      p_q     <= '0;
      d_q     <= '0;
      i_q     <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
    end else begin
      vld_q <= {vld_q[1:0], bus.err_vld};
      if (bus.err_vld) es_q <= es_d;
      if (vld_q[0]) begin
        p_q <= p_d;
        d_q <= d_d;
      end
      // not moving: integrator/history cleared every edge, a sample in S2 sees a zero integrator
      if (!bus.moving) begin
        integ_q <= '0;
        for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
        if (vld_q[0]) i_q <= '0;
      end else if (vld_q[0]) begin
        integ_q   <= integ_d;
        i_q       <= i_d;
        hist_q[0] <= es_q;
        for (int k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
      end
      if (vld_q[1]) begin
        lft_q  <= lft_d;
        rght_q <= rght_d;
      end
    end
  end

  assign bus.spd_vld  = vld_q[2];
  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;

endmodule

// File: tb/tb_pid_ctrl_gen2.sv
// Directed bench for pid_ctrl_gen2: table of single/back-to-back strobes with hand-computed
// speeds, plus sequences for integrator clamp, moving drop and reset with samples in flight.
module tb_pid_ctrl_gen2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  pid_ctrl_gen2_if b ();
  pid_ctrl_gen2 dut (.clk(clk), .rst_n(rst_n), .bus(b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    l;
    int    r;
    int    c;
    string tag;
  } exp_t;

  typedef struct {
    int grp;
    int err;
    int frwrd;
    int p;
    int d;
    int el;
    int er;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t tv[15];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Output monitor: every spd_vld pulse is matched against the next expected record
  always @(negedge clk) begin
    if (rst_n && b.spd_vld) begin
      if (q.size() == 0) check("spurious_spd_vld", 1, 0);
      else begin
        mon_e = q.pop_front();
        check({mon_e.tag, "_lft"}, int'(b.lft_spd), mon_e.l);
        check({mon_e.tag, "_rght"}, int'(b.rght_spd), mon_e.r);
        check({mon_e.tag, "_latency"}, cyc, mon_e.c);
      end
    end
  end

  task automatic strobe(input int e, input logic mov, input int el, input int er, input string tag);
    exp_t x;
    b.err_vld = 1'b1;
    b.error   = 12'(e);
    b.moving  = mov;
    x.l = el; x.r = er; x.c = cyc + 3; x.tag = tag;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle();
    b.err_vld = 1'b0;
    b.moving  = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      idle();
      n++;
    end
    if (q.size() > 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_reset();
    b.err_vld = 1'b0;
    b.moving  = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cfg(input int fr, input int p, input int d);
    b.frwrd   = 10'(fr);
    b.p_coeff = 6'(p);
    b.d_coeff = 5'(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iv;
    int t;

    tv[0]  = '{1, 2047, 256, 16, 7, 879, -367};
    tv[1]  = '{2, 511, 1023, 16, 7, 1023, 400};
    tv[2]  = '{2, 511, 1023, 16, 7, 1023, 399};
    tv[3]  = '{2, 511, 1023, 16, 7, 1023, 398};
    tv[4]  = '{2, 511, 1023, 16, 7, 1023, 509};
    tv[5]  = '{3, -2048, 0, 63, 7, -1024, 1023};
    tv[6]  = '{4, 0, 0, 0, 7, 0, 0};
    tv[7]  = '{4, 0, 0, 0, 7, 0, 0};
    tv[8]  = '{4, 0, 0, 0, 7, 0, 0};
    tv[9]  = '{4, 100, 0, 0, 7, 87, -87};
    tv[10] = '{4, 100, 0, 0, 7, 87, -87};
    tv[11] = '{4, 100, 0, 0, 7, 88, -88};
    tv[12] = '{4, 100, 0, 0, 7, 0, 0};
    tv[13] = '{4, 100, 0, 0, 7, 0, 0};
    tv[14] = '{4, 400, 0, 0, 7, 112, -112};

    rst_n     = 1'b0;
    b.err_vld = 1'b0;
    b.error   = '0;
    b.moving  = 1'b1;
    set_cfg(0, 16, 7);
    repeat (2) @(negedge clk);
    check("reset_spd_vld", int'(b.spd_vld), 0);
    check("reset_lft", int'(b.lft_spd), 0);
    check("reset_rght", int'(b.rght_spd), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      if (i == 0 || tv[i].grp != tv[i-1].grp) begin
        drain();
        do_reset();
        set_cfg(tv[i].frwrd, tv[i].p, tv[i].d);
      end
      strobe(tv[i].err, 1'b1, tv[i].el, tv[i].er, $sformatf("vec%0d", i));
    end
    drain();

    // Integrator clamps at 16383 from strobe 33 on, then unwinds immediately
    do_reset();
    set_cfg(0, 0, 0);
    iv = 0;
    for (int k = 1; k <= 40; k++) begin
      iv = iv + 511;
      if (iv > 16383) iv = 16383;
      t = iv >>> 9;
      strobe(511, 1'b1, t, -t, $sformatf("isat%0d", k));
    end
    for (int k = 1; k <= 3; k++) begin
      iv = iv - 511;
      t = iv >>> 9;
      strobe(-511, 1'b1, t, -t, $sformatf("iunwind%0d", k));
    end
    drain();

    // moving low for the cycle of strobe 21: strobe 19 leaves S3 as zero, strobe 20 sees cleared integ
    do_reset();
    set_cfg(100, 0, 0);
    iv = 0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 20) iv = 0;
      else iv = iv + 511;
      t = iv >>> 9;
      if (k == 19) strobe(511, 1'b1, 0, 0, $sformatf("mov%0d", k));
      else strobe(511, (k != 21), 100 + t, 100 - t, $sformatf("mov%0d", k));
    end
    drain();

    // Reset with samples in flight: outputs drop asynchronously, nothing emerges afterwards
    do_reset();
    set_cfg(256, 16, 7);
    strobe(2047, 1'b1, 879, -367, "pre_rst");
    drain();
    b.err_vld = 1'b1;
    b.error   = 12'(300);
    @(negedge clk);
    b.error   = 12'(-300);
    @(negedge clk);
    b.error   = 12'(200);
    #2;
    b.err_vld = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("async_rst_lft", int'(b.lft_spd), 0);
    check("async_rst_rght", int'(b.rght_spd), 0);
    check("async_rst_vld", int'(b.spd_vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_vld%0d", k), int'(b.spd_vld), 0);
    end
    check("post_rst_lft", int'(b.lft_spd), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
